// File: rtl/qpmm_seq_pkg.sv
// Shared types and defaults for the QPMM issue sequencer.
// Optional feature macro: QPMM_SEQ_PERF_EN (perf_ops / perf_stall counters).
package qpmm_seq_pkg;

  localparam int unsigned QPMM_ADDR_W  = 8;
  localparam int unsigned QPMM_TAG_W   = 4;
  localparam int unsigned QPMM_RD_LAT  = 3;
  localparam int unsigned QPMM_MUL_LAT = 32;

  // Command payload at the default widths.
  typedef struct packed {
    logic [QPMM_ADDR_W-1:0] src_a;
    logic [QPMM_ADDR_W-1:0] src_b;
    logic [QPMM_ADDR_W-1:0] dst;
    logic [QPMM_TAG_W-1:0]  tag;
  } qpmm_cmd_t;

  // One tracking-line entry at the default widths.
  typedef struct packed {
    logic                   v;
    logic [QPMM_ADDR_W-1:0] dst;
    logic [QPMM_TAG_W-1:0]  tag;
  } qpmm_stage_t;

  // Tracking depth: issue stage, RAM read latency, multiplier latency.
  function automatic int unsigned qpmm_depth(input int unsigned rd_lat,
                                             input int unsigned mul_lat);
    return 1 + rd_lat + mul_lat;
  endfunction

endpackage

// File: rtl/qpmm_seq_scoreboard.sv
// D-stage tracking line with parallel destination match for RAW hazards.
// Optional feature macro: QPMM_SEQ_PERF_EN (not used in this file).
import qpmm_seq_pkg::*;

module qpmm_seq_scoreboard #(
  parameter int unsigned ADDR_W = QPMM_ADDR_W,
  parameter int unsigned TAG_W  = QPMM_TAG_W,
  parameter int unsigned DEPTH  = qpmm_depth(QPMM_RD_LAT, QPMM_MUL_LAT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_dst_i,
  input  logic [TAG_W-1:0]  push_tag_i,
  input  logic [ADDR_W-1:0] chk_a_i,
  input  logic [ADDR_W-1:0] chk_b_i,
  output logic              hazard_o,
  output logic              tail_v_o,
  output logic [ADDR_W-1:0] tail_dst_o,
  output logic [TAG_W-1:0]  tail_tag_o,
  output logic              busy_o
);

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] dst;
    logic [TAG_W-1:0]  tag;
  } stage_t;

  stage_t stage_q [DEPTH];

  // Shift the line every cycle; payload only advances with a valid entry so
  // the last stage keeps its dst/tag across bubbles (holds wr_addr/done_tag).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0].v <= push_i;
      if (push_i) begin
        stage_q[0].dst <= push_dst_i;
        stage_q[0].tag <= push_tag_i;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i].v <= stage_q[i-1].v;
        if (stage_q[i-1].v) begin
          stage_q[i].dst <= stage_q[i-1].dst;
          stage_q[i].tag <= stage_q[i-1].tag;
        end
      end
    end
  end

  // Match both candidate sources against every valid in-flight destination.
  always_comb begin
    hazard_o = '0;
    busy_o   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (stage_q[i].v) begin
        busy_o = '1;
        if (stage_q[i].dst == chk_a_i || stage_q[i].dst == chk_b_i) hazard_o = '1;
      end
    end
  end

  assign tail_v_o   = stage_q[DEPTH-1].v;
  assign tail_dst_o = stage_q[DEPTH-1].dst;
  assign tail_tag_o = stage_q[DEPTH-1].tag;

endmodule

// File: rtl/qpmm_sequencer.sv
// QPMM issue controller: command handshake, operand read addresses,
// mirrored write-back timing and completion reporting.
// Optional feature macro: QPMM_SEQ_PERF_EN adds perf_ops / perf_stall.
import qpmm_seq_pkg::*;

module qpmm_sequencer #(
  parameter int unsigned ADDR_W  = QPMM_ADDR_W,
  parameter int unsigned TAG_W   = QPMM_TAG_W,
  parameter int unsigned RD_LAT  = QPMM_RD_LAT,
  parameter int unsigned MUL_LAT = QPMM_MUL_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              done_valid,
  output logic [TAG_W-1:0]  done_tag,
  output logic              busy
`ifdef QPMM_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_stall
`endif
);

  localparam int unsigned D = qpmm_depth(RD_LAT, MUL_LAT);

  logic              hazard;
  logic              accept;
  logic              tail_v;
  logic [ADDR_W-1:0] tail_dst;
  logic [TAG_W-1:0]  tail_tag;
  logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [ADDR_W-1:0] rd_addr_b_q, rd_addr_b_d;

  assign cmd_ready = !hazard;
  assign accept    = cmd_valid && cmd_ready;

  qpmm_seq_scoreboard #(
    .ADDR_W (ADDR_W),
    .TAG_W  (TAG_W),
    .DEPTH  (D)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push_i     (accept),
    .push_dst_i (cmd_dst),
    .push_tag_i (cmd_tag),
    .chk_a_i    (cmd_src_a),
    .chk_b_i    (cmd_src_b),
    .hazard_o   (hazard),
    .tail_v_o   (tail_v),
    .tail_dst_o (tail_dst),
    .tail_tag_o (tail_tag),
    .busy_o     (busy)
  );

  // Read addresses follow the accepted command and hold otherwise.
  always_comb begin
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    if (accept) begin
      rd_addr_a_d = cmd_src_a;
      rd_addr_b_d = cmd_src_b;
    end
  end

  // Register the read-address ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
    end else begin
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
    end
  end

  assign rd_addr_a  = rd_addr_a_q;
  assign rd_addr_b  = rd_addr_b_q;
  assign wr_en      = tail_v;
  assign done_valid = tail_v;
  assign wr_addr    = tail_dst;
  assign done_tag   = tail_tag;

`ifdef QPMM_SEQ_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Count accepts and stalled-command cycles, wrapping at 2^32.
  always_comb begin
    perf_ops_d   = perf_ops_q + {31'd0, accept};
    perf_stall_d = perf_stall_q + {31'd0, cmd_valid && !cmd_ready};
  end

  // Register the performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_qpmm_sequencer.sv
// Self-checking bench for qpmm_sequencer with RD_LAT=3, MUL_LAT=4 (D=8).
// Perf counter checks are compiled in only when QPMM_SEQ_PERF_EN is defined.
module tb_qpmm_sequencer;

  localparam int D = 8;

  logic       clk, rst, cmd_valid, cmd_ready;
  logic [7:0] cmd_src_a, cmd_src_b, cmd_dst;
  logic [3:0] cmd_tag;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr;
  logic       wr_en, done_valid, busy;
  logic [3:0] done_tag;
`ifdef QPMM_SEQ_PERF_EN
  logic [31:0] perf_ops, perf_stall;
`endif

  qpmm_sequencer #(
    .ADDR_W  (8),
    .TAG_W   (4),
    .RD_LAT  (3),
    .MUL_LAT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_src_a  (cmd_src_a),
    .cmd_src_b  (cmd_src_b),
    .cmd_dst    (cmd_dst),
    .cmd_tag    (cmd_tag),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .done_valid (done_valid),
    .done_tag   (done_tag),
    .busy       (busy)
`ifdef QPMM_SEQ_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dst;
    logic [3:0] tag;
    int         due;
  } exp_t;

  exp_t       q[$];
  logic [7:0] exp_rda, exp_rdb;
  logic       rdy_exp, wr_exp;
  int         n_cmp, n_bad;

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0;
    cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0; cmd_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    q.delete(); exp_rda = '0; exp_rdb = '0;
    n_cmp++;
    if ({rd_addr_a, rd_addr_b, wr_addr, wr_en, done_valid, done_tag, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs got ra=%0d rb=%0d wa=%0d we=%b dv=%b dt=%0d busy=%b exp all 0",
               rd_addr_a, rd_addr_b, wr_addr, wr_en, done_valid, done_tag, busy);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready got %b exp 1", cmd_ready);
    end
  endtask

  task automatic test_single();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      cmd_valid = (c == 0);
      cmd_src_a = 8'd1; cmd_src_b = 8'd2; cmd_dst = 8'd5; cmd_tag = 4'd7;
      #1;
      rdy_exp = 1'b1;
      foreach (q[k]) if (q[k].dst == cmd_src_a || q[k].dst == cmd_src_b) rdy_exp = 1'b0;
      n_cmp++;
      if (cmd_ready !== rdy_exp) begin n_bad++; $display("FAIL single_ready c=%0d got %b exp %b", c, cmd_ready, rdy_exp); end
      n_cmp++;
      if (busy !== (q.size() != 0)) begin n_bad++; $display("FAIL single_busy c=%0d got %b exp %b", c, busy, q.size() != 0); end
      n_cmp++;
      if (rd_addr_a !== exp_rda || rd_addr_b !== exp_rdb) begin
        n_bad++; $display("FAIL single_rd c=%0d got %0d/%0d exp %0d/%0d", c, rd_addr_a, rd_addr_b, exp_rda, exp_rdb);
      end
      wr_exp = (q.size() != 0) && (q[0].due == c);
      n_cmp++;
      if (wr_en !== wr_exp || done_valid !== wr_exp) begin
        n_bad++; $display("FAIL single_wr c=%0d got we=%b dv=%b exp %b", c, wr_en, done_valid, wr_exp);
      end
      if (wr_exp) begin
        n_cmp++;
        if (wr_addr !== q[0].dst || done_tag !== q[0].tag) begin
          n_bad++; $display("FAIL single_wb c=%0d got wa=%0d dt=%0d exp %0d/%0d", c, wr_addr, done_tag, q[0].dst, q[0].tag);
        end
        void'(q.pop_front());
      end
      if (cmd_valid && rdy_exp) begin
        q.push_back('{cmd_dst, cmd_tag, c + D}); exp_rda = cmd_src_a; exp_rdb = cmd_src_b;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      cmd_valid = (c < 4);
      cmd_src_a = 8'(30 + c); cmd_src_b = 8'(40 + c); cmd_dst = 8'(10 + c); cmd_tag = 4'(c);
      #1;
      rdy_exp = 1'b1;
      foreach (q[k]) if (q[k].dst == cmd_src_a || q[k].dst == cmd_src_b) rdy_exp = 1'b0;
      n_cmp++;
      if (cmd_ready !== rdy_exp) begin n_bad++; $display("FAIL b2b_ready c=%0d got %b exp %b", c, cmd_ready, rdy_exp); end
      n_cmp++;
      if (busy !== (q.size() != 0)) begin n_bad++; $display("FAIL b2b_busy c=%0d got %b exp %b", c, busy, q.size() != 0); end
      n_cmp++;
      if (rd_addr_a !== exp_rda || rd_addr_b !== exp_rdb) begin
        n_bad++; $display("FAIL b2b_rd c=%0d got %0d/%0d exp %0d/%0d", c, rd_addr_a, rd_addr_b, exp_rda, exp_rdb);
      end
      wr_exp = (q.size() != 0) && (q[0].due == c);
      n_cmp++;
      if (wr_en !== wr_exp || done_valid !== wr_exp) begin
        n_bad++; $display("FAIL b2b_wr c=%0d got we=%b dv=%b exp %b", c, wr_en, done_valid, wr_exp);
      end
      if (wr_exp) begin
        n_cmp++;
        if (wr_addr !== q[0].dst || done_tag !== q[0].tag) begin
          n_bad++; $display("FAIL b2b_wb c=%0d got wa=%0d dt=%0d exp %0d/%0d", c, wr_addr, done_tag, q[0].dst, q[0].tag);
        end
        void'(q.pop_front());
      end
      if (cmd_valid && rdy_exp) begin
        q.push_back('{cmd_dst, cmd_tag, c + D}); exp_rda = cmd_src_a; exp_rdb = cmd_src_b;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_raw();
    bit op1_done = 1'b0;
    int stalls = 0;
    int acc_c = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        cmd_valid = 1'b1; cmd_src_a = 8'd20; cmd_src_b = 8'd21; cmd_dst = 8'd5; cmd_tag = 4'd1;
      end else begin
        cmd_valid = !op1_done; cmd_src_a = 8'd5; cmd_src_b = 8'd22; cmd_dst = 8'd6; cmd_tag = 4'd2;
      end
      #1;
      rdy_exp = 1'b1;
      foreach (q[k]) if (q[k].dst == cmd_src_a || q[k].dst == cmd_src_b) rdy_exp = 1'b0;
      n_cmp++;
      if (cmd_ready !== rdy_exp) begin n_bad++; $display("FAIL raw_ready c=%0d got %b exp %b", c, cmd_ready, rdy_exp); end
      n_cmp++;
      if (busy !== (q.size() != 0)) begin n_bad++; $display("FAIL raw_busy c=%0d got %b exp %b", c, busy, q.size() != 0); end
      n_cmp++;
      if (rd_addr_a !== exp_rda || rd_addr_b !== exp_rdb) begin
        n_bad++; $display("FAIL raw_rd c=%0d got %0d/%0d exp %0d/%0d", c, rd_addr_a, rd_addr_b, exp_rda, exp_rdb);
      end
      wr_exp = (q.size() != 0) && (q[0].due == c);
      n_cmp++;
      if (wr_en !== wr_exp || done_valid !== wr_exp) begin
        n_bad++; $display("FAIL raw_wr c=%0d got we=%b dv=%b exp %b", c, wr_en, done_valid, wr_exp);
      end
      if (wr_exp) begin
        n_cmp++;
        if (wr_addr !== q[0].dst || done_tag !== q[0].tag) begin
          n_bad++; $display("FAIL raw_wb c=%0d got wa=%0d dt=%0d exp %0d/%0d", c, wr_addr, done_tag, q[0].dst, q[0].tag);
        end
        void'(q.pop_front());
      end
      if (c > 0 && cmd_valid && cmd_ready === 1'b0) stalls++;
      if (c > 0 && cmd_valid && cmd_ready === 1'b1) acc_c = c;
      if (cmd_valid && rdy_exp) begin
        q.push_back('{cmd_dst, cmd_tag, c + D}); exp_rda = cmd_src_a; exp_rdb = cmd_src_b;
        if (c > 0) op1_done = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (acc_c != 9) begin n_bad++; $display("FAIL raw_accept_cycle got %0d exp 9", acc_c); end
    n_cmp++;
    if (stalls != 8) begin n_bad++; $display("FAIL raw_stall_cycles got %0d exp 8", stalls); end
`ifdef QPMM_SEQ_PERF_EN
    n_cmp++;
    if (perf_ops !== 32'd2) begin n_bad++; $display("FAIL perf_ops got %0d exp 2", perf_ops); end
    n_cmp++;
    if (perf_stall !== 32'd8) begin n_bad++; $display("FAIL perf_stall got %0d exp 8", perf_stall); end
`endif
  endtask

  task automatic test_midflight_reset();
    for (int c = 0; c < 21; c++) begin
      @(posedge clk); #1;
      rst = (c == 3);
      cmd_valid = (c < 2);
      cmd_src_a = 8'(60 + c); cmd_src_b = 8'(70 + c); cmd_dst = 8'(50 + c); cmd_tag = 4'(9 + c);
      #1;
      rdy_exp = 1'b1;
      foreach (q[k]) if (q[k].dst == cmd_src_a || q[k].dst == cmd_src_b) rdy_exp = 1'b0;
      n_cmp++;
      if (cmd_ready !== rdy_exp) begin n_bad++; $display("FAIL mid_ready c=%0d got %b exp %b", c, cmd_ready, rdy_exp); end
      n_cmp++;
      if (busy !== (q.size() != 0)) begin n_bad++; $display("FAIL mid_busy c=%0d got %b exp %b", c, busy, q.size() != 0); end
      n_cmp++;
      if (rd_addr_a !== exp_rda || rd_addr_b !== exp_rdb) begin
        n_bad++; $display("FAIL mid_rd c=%0d got %0d/%0d exp %0d/%0d", c, rd_addr_a, rd_addr_b, exp_rda, exp_rdb);
      end
      wr_exp = (q.size() != 0) && (q[0].due == c);
      n_cmp++;
      if (wr_en !== wr_exp || done_valid !== wr_exp) begin
        n_bad++; $display("FAIL mid_wr c=%0d got we=%b dv=%b exp %b", c, wr_en, done_valid, wr_exp);
      end
      if (wr_exp) void'(q.pop_front());
      if (cmd_valid && rdy_exp) begin
        q.push_back('{cmd_dst, cmd_tag, c + D}); exp_rda = cmd_src_a; exp_rdb = cmd_src_b;
      end
      if (rst) begin
        q.delete(); exp_rda = '0; exp_rdb = '0;
      end
    end
    rst = 1'b0; cmd_valid = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; cmd_valid = 1'b0;
    cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0; cmd_tag = '0;
    n_cmp = 0; n_bad = 0;
    exp_rda = '0; exp_rdb = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset();
    test_raw();
    test_midflight_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qpmm_sequencer.md
# qpmm_sequencer

Issue controller for the QPMM modular-multiplier datapath. It accepts multiply commands (two source addresses, one destination address, one tag) over a valid/ready handshake and drives the read ports of the two operand RAMs: bank 0 feeds A, bank 1 feeds B. It then tracks each operation through the RAM read latency and multiplier latency and asserts the mirrored write-back (same address, both banks) exactly when Z is valid. It issues one independent operation per cycle and stalls read-after-write hazards against in-flight destinations.

## Interface
Parameters:
- ADDR_W, 8, RAM address width (both banks)
- TAG_W, 4, command tag width
- RD_LAT, 3, cycles from read address to RAM doutb valid
- MUL_LAT, 32, cycles from A/B valid to Z valid (QPMM pipeline depth)

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_src_a  in  ADDR_W  bank-0 address of operand A
- cmd_src_b  in  ADDR_W  bank-1 address of operand B
- cmd_dst  in  ADDR_W  write-back address (both banks)
- cmd_tag  in  TAG_W  returned with completion
- rd_addr_a  out  ADDR_W  to bank-0 addrb
- rd_addr_b  out  ADDR_W  to bank-1 addrb
- wr_addr  out  ADDR_W  to addra of both banks
- wr_en  out  1  to wea of both banks
- done_valid  out  1  one-cycle completion pulse
- done_tag  out  TAG_W  tag of the completing operation
- busy  out  1  any operation in flight
- perf_ops, perf_stall  out  32 each  (only with QPMM_SEQ_PERF_EN)

## Operation
- Tracking line of D = 1 + RD_LAT + MUL_LAT stages. Each stage holds {v, dst, tag}. It shifts every cycle; no back-pressure from the datapath.
- An accept at cycle t loads stage 1 at t+1. At t+1, rd_addr_a/rd_addr_b equal that command's src_a/src_b (registered outputs).
- When stage D is valid: wr_en=1, wr_addr=stage D dst, done_valid=1, done_tag=stage D tag, all in the same cycle.
- Hazard: cmd_ready=0 if cmd_src_a or cmd_src_b equals the dst of any valid stage 1..D. This includes the stage being written that cycle. cmd_ready may depend combinationally on the cmd_* payload; cmd_ready never depends on cmd_valid.
- With no hazard, cmd_ready=1. Independent commands issue back-to-back at 1/cycle.
- WAW (same dst, both in flight) is legal; writes occur in issue order.
- src_a == src_b, or src == dst of the same command, is legal (no self-hazard).
- rd_addr_a/b hold their last value when no command is issued. wr_addr holds its value when wr_en=0.
- busy = OR of stage valids.
- Reset: all stage valids cleared. rd_addr_a/b, wr_addr, wr_en, done_valid, done_tag=0; busy=0. cmd_ready=1 (no entries). Reset mid-flight discards all operations; no wr_en/done for them, ever.

## Timing
- Accept at t -> read addresses at t+1 -> Z valid and write/done at t+D (default D=36).
- Dependent command: earliest accept is t+D+1. Its read is at t+D+2, after the write has landed.
- Throughput: 1 op/cycle without hazards. Completions are in issue order.
- Outputs are registered, except cmd_ready (combinational compare against the registered stages).

## Configuration
- QPMM_SEQ_PERF_EN defined:
  - perf_ops counts accepts.
  - perf_stall counts cycles with cmd_valid && !cmd_ready.
  - Both are 32-bit, wrap modulo 2^32 and clear on rst.
- Undefined: perf ports and counters are absent; all other behaviour is identical.

## Structure
- Package qpmm_seq_pkg holds:
  - typedef of the command struct {src_a, src_b, dst, tag}
  - typedef of the tracking-stage struct {v, dst, tag}
  - default ADDR_W/TAG_W/RD_LAT/MUL_LAT constants
  - function computing D
- Sub-module qpmm_seq_scoreboard holds the D-stage tracking line and the parallel dst-match logic. It outputs hazard, the stage-D entry and busy.
- The top handles handshake, address registers and perf counters.

## Test plan
All scenarios use RD_LAT=3, MUL_LAT=4, so D=8.
- Reset: rst held 2 cycles, then released -> all outputs 0, cmd_ready=1, busy=0.
- Single op accepted at cycle 0 (src_a=1, src_b=2, dst=5, tag=7) -> cycle 1: rd_addr_a=1, rd_addr_b=2. Cycle 8 only: wr_en=1, wr_addr=5, done_valid=1, done_tag=7. busy=0 from cycle 9.
- Four independent ops, cycles 0-3 (dst 10-13, tags 0-3) -> cmd_ready stays 1. Writes at cycles 8-11 with wr_addr 10,11,12,13 and done_tag 0,1,2,3.
- RAW: op0 dst=5 at cycle 0; op1 src_a=5 valid from cycle 1 -> cmd_ready=0 on cycles 1-8, accepted at cycle 9, write at cycle 17.
- Reset mid-flight: 2 ops accepted at cycles 0-1, rst at cycle 3 -> no wr_en/done_valid in cycles 4-20; busy=0 from cycle 4.
- QPMM_SEQ_PERF_EN defined, after the RAW scenario -> perf_ops=2, perf_stall=8. Built without the macro, the perf ports are absent and the RAW scenario passes unchanged.
